mux_stream_nway: RTL and testbench
==================================

MUX_STREAM_NWAY -- requirements
Module: mux_stream_nway

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width per channel, legal 1..64.
REQ-002 SHALL have parameter CHANNELS, default 4: number of input channels, legal 2..16.
REQ-003 SHALL derive local parameter SEL_W = max(1, clog2(CHANNELS)); it SHALL NOT be overridable.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports are clk and rst_n.
REQ-005 Port clk, input, 1: rising-edge clock for all state.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port mode, input, 1: 0 = select mode (control picks the channel), 1 = round-robin mode.
REQ-008 Port control, input, SEL_W: channel index used in select mode.
REQ-009 Port in_data, input, CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 Port in_valid, input, CHANNELS: per-channel valid.
REQ-011 Port in_ready, output, CHANNELS: per-channel ready; at most one bit is set.
REQ-012 Port out_data, output, WIDTH: registered selected data.
REQ-013 Port out_valid, output, 1: out_data holds a beat.
REQ-014 Port out_ready, input, 1: the downstream accepts the beat.
REQ-015 Port out_chan, output, SEL_W: source channel index of the held beat.

Function
REQ-016 SHALL define slot_free = !out_valid || out_ready, combinational.
REQ-017 Grant in select mode: grant channel control, provided control < CHANNELS and in_valid[control] = 1; otherwise no grant.
REQ-018 Grant in round-robin mode: grant the first channel with in_valid set, searching from (rr_ptr+1) mod CHANNELS upward with wrap.
REQ-019 Priority state: rr_ptr (SEL_W bits) SHALL update to the granted index only on an accepted input beat.
REQ-020 Input handshake: in_ready[g] = slot_free for the granted channel g; all other in_ready bits SHALL be 0.
REQ-021 Input accept: when in_valid[g] && in_ready[g], out_data <= in_data[g], out_chan <= g, and out_valid <= 1 on the next rising edge. Latency is 1 cycle.
REQ-022 Output drain: when out_valid && out_ready and no input is accepted in that cycle, out_valid SHALL go to 0 on the next edge.
REQ-023 Simultaneous drain and accept: in the same cycle, the register SHALL load the new beat, giving full throughput of 1 beat per cycle.
REQ-024 Backpressure: while out_valid && !out_ready, out_data and out_chan SHALL stay stable and all in_ready bits SHALL be 0.
REQ-025 Mode or control change while a beat is held SHALL NOT alter the held beat; the change takes effect on the next grant.
REQ-026 in_ready SHALL depend on in_valid, mode, control, rr_ptr, out_valid and out_ready only; there SHALL be no path from in_data.

Reset
REQ-027 On rst_n low, asynchronously: out_valid = 0, out_data = 0, out_chan = 0, rr_ptr = CHANNELS-1 (so channel 0 is searched first).
REQ-028 Reset mid-transfer SHALL discard the held beat; in_ready SHALL be 0 while rst_n is low.
REQ-029 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro MUX_STREAM_RR_EN defined: round-robin mode and rr_ptr are compiled in, as in REQ-018 and REQ-019.
REQ-031 Macro MUX_STREAM_RR_EN undefined: rr_ptr is absent, mode is ignored, and the block always behaves as in select mode.

Verification
REQ-032 Select mode, CHANNELS=4, control=2, in_valid=4'b0100, in_data ch2=32'd5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=5, out_chan=2.
REQ-033 Round-robin mode, all in_valid=1, out_ready=1 for 6 cycles -> out_chan sequence 0,1,2,3,0,1 with one beat every cycle.
REQ-034 Hold out_ready=0 for 3 cycles with a beat held -> out_data and out_chan stable and in_ready=0; the cycle out_ready returns to 1 -> the next beat loads the following edge.
REQ-035 Select mode, control=2 with in_valid[2]=0 and other channels valid -> no grant and out_valid stays 0; control=3 with CHANNELS=3 -> no grant.
REQ-036 Assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0 immediately without a clock edge; after release, round-robin grants channel 0 first.
REQ-037 Build without MUX_STREAM_RR_EN, mode=1, control=1 -> channel 1 is selected exactly as in select mode.

Source files
------------

// File: rtl/mux_stream_nway.sv
// N-way stream multiplexer with a one-beat registered output slot.
// Optional round-robin arbitration is compiled in with `define MUX_STREAM_RR_EN.
module mux_stream_nway #(
  parameter  int WIDTH    = 32,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          control,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  logic             slot_free;
  logic             accept;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             sel_vld;
  logic [SEL_W-1:0] sel_idx;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] chan_p1;

  // Select mode: an out-of-range control index matches no channel, so no grant.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (control == SEL_W'(i) && in_valid[i]) begin
        sel_vld = 1'b1;
        sel_idx = SEL_W'(i);
      end
    end
  end

`ifdef MUX_STREAM_RR_EN
  logic [SEL_W-1:0] rr_ptr;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_idx;

  // Walk offsets from farthest to nearest so the channel closest after rr_ptr wins.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      if (in_valid[(int'(rr_ptr) + k) % CHANNELS]) begin
        rr_vld = 1'b1;
        rr_idx = SEL_W'((int'(rr_ptr) + k) % CHANNELS);
      end
    end
  end

  assign grant_vld = mode ? rr_vld : sel_vld;
  assign grant_idx = mode ? rr_idx : sel_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= SEL_W'(CHANNELS - 1);
    end else if (accept) begin
      rr_ptr <= grant_idx;
    end
  end
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign grant_vld   = sel_vld;
  assign grant_idx   = sel_idx;
`endif

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // The slot can take a beat when empty or when its beat leaves this cycle.
  assign slot_free = !vld_p1 || out_ready;
  assign accept    = rst_n && grant_vld && slot_free;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = accept && (grant_idx == SEL_W'(i));
    end
  end

  // Stage p1: output register slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= grant_data;
      chan_p1 <= grant_idx;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_chan  = chan_p1;

endmodule

// File: tb/tb_mux_stream_nway.sv
// Self-checking bench for mux_stream_nway: vector table, corner sequences,
// and randomized traffic against a behavioural model of the arbitration rules.
module tb_mux_stream_nway;

`ifdef MUX_STREAM_RR_EN
  localparam bit RR_ON = 1'b1;
`else
  localparam bit RR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode;
  logic [1:0]   control;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_chan;

  logic         mode3;
  logic [1:0]   control3;
  logic [23:0]  in_data3;
  logic [2:0]   in_valid3;
  logic [2:0]   in_ready3;
  logic [7:0]   out_data3;
  logic         out_valid3;
  logic         out_ready3;
  logic [1:0]   out_chan3;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_stream_nway #(.WIDTH(32), .CHANNELS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .control(control),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan)
  );

  mux_stream_nway #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .control(control3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_chan(out_chan3)
  );

  typedef struct {
    logic [1:0]  ctl;
    logic [3:0]  iv;
    logic        ordy;
    logic [31:0] dbase;
    logic [3:0]  exp_ir;
    logic        exp_vld;
    logic [31:0] exp_data;
    logic [1:0]  exp_chan;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit md, input logic [1:0] ctl, input logic [3:0] iv,
                       input bit ordy, input logic [31:0] base);
    mode      = md;
    control   = ctl;
    in_valid  = iv;
    out_ready = ordy;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = base + 32'(i);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: -1 means no channel is granted.
  function automatic int ref_grant(input bit md, input int ctl, input logic [3:0] iv, input int ptr);
    if (RR_ON && md) begin
      for (int off = 1; off <= 4; off++) begin
        if (iv[(ptr + off) % 4]) return (ptr + off) % 4;
      end
      return -1;
    end
    if (ctl < 4 && iv[ctl]) return ctl;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_c;
    int          g;
    bit          m_vld;
    logic [31:0] m_data;
    int          m_chan;
    int          m_ptr;
    logic [31:0] rd [4];
    logic [3:0]  exp_ir;

    tbl[0] = '{2'd2, 4'b0100, 1'b1, 32'd3,  4'b0100, 1'b1, 32'd5,  2'd2};
    tbl[1] = '{2'd2, 4'b1011, 1'b1, 32'd10, 4'b0000, 1'b0, 32'd5,  2'd2};
    tbl[2] = '{2'd0, 4'b0001, 1'b0, 32'd20, 4'b0001, 1'b1, 32'd20, 2'd0};
    tbl[3] = '{2'd1, 4'b0010, 1'b0, 32'd30, 4'b0000, 1'b1, 32'd20, 2'd0};
    tbl[4] = '{2'd1, 4'b0010, 1'b1, 32'd40, 4'b0010, 1'b1, 32'd41, 2'd1};
    tbl[5] = '{2'd3, 4'b1000, 1'b1, 32'd50, 4'b1000, 1'b1, 32'd53, 2'd3};
    tbl[6] = '{2'd3, 4'b0111, 1'b1, 32'd60, 4'b0000, 1'b0, 32'd53, 2'd3};
    tbl[7] = '{2'd3, 4'b1111, 1'b0, 32'd70, 4'b1000, 1'b1, 32'd73, 2'd3};

    mode3 = 1'b0; control3 = 2'd0; in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b1;
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 4'b1111, 1'b1, 32'd0);
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_chan",  64'(out_chan),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    #11 rst_n = 1'b1;

    // Vector table, applied back to back from reset
    for (int v = 0; v < 8; v++) begin
      drive(1'b0, tbl[v].ctl, tbl[v].iv, tbl[v].ordy, tbl[v].dbase);
      #1;
      check($sformatf("tbl%0d_in_ready", v), 64'(in_ready), 64'(tbl[v].exp_ir));
      tick;
      check($sformatf("tbl%0d_out_valid", v), 64'(out_valid), 64'(tbl[v].exp_vld));
      check($sformatf("tbl%0d_out_data", v),  64'(out_data),  64'(tbl[v].exp_data));
      check($sformatf("tbl%0d_out_chan", v),  64'(out_chan),  64'(tbl[v].exp_chan));
    end

    // Backpressure: held beat (73, ch3) stays put for three stalled cycles
    for (int r = 0; r < 3; r++) begin
      drive(1'b0, 2'd1, 4'b1111, 1'b0, 32'(200 + r*10));
      #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      tick;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_data",  64'(out_data),  64'd73);
      check("bp_out_chan",  64'(out_chan),  64'd3);
    end
    drive(1'b0, 2'd1, 4'b1111, 1'b1, 32'd300);
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'b0010);
    tick;
    check("bp_release_valid", 64'(out_valid), 64'd1);
    check("bp_release_data",  64'(out_data),  64'd301);
    check("bp_release_chan",  64'(out_chan),  64'd1);
    drive(1'b0, 2'd1, 4'b0000, 1'b1, 32'd0);
    #1;
    check("drain_in_ready", 64'(in_ready), 64'd0);
    tick;
    check("drain_out_valid", 64'(out_valid), 64'd0);

    // Three-channel instance: control beyond the last channel grants nothing
    control3 = 2'd3; in_valid3 = 3'b011; in_data3 = 24'h332211;
    #1;
    check("c3_oob_in_ready", 64'(in_ready3), 64'd0);
    tick;
    check("c3_oob_out_valid", 64'(out_valid3), 64'd0);
    control3 = 2'd1;
    #1;
    check("c3_sel_in_ready", 64'(in_ready3), 64'b010);
    tick;
    check("c3_sel_out_valid", 64'(out_valid3), 64'd1);
    check("c3_sel_out_data",  64'(out_data3),  64'h22);
    check("c3_sel_out_chan",  64'(out_chan3),  64'd1);
    in_valid3 = 3'b000;

    // Asynchronous reset in the middle of a stream
    drive(1'b1, 2'd1, 4'b1111, 1'b1, 32'd400);
    tick;
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_out_data",  64'(out_data),  64'd0);
    check("async_rst_in_ready",  64'(in_ready),  64'd0);
    #2 rst_n = 1'b1;

    // Round-robin rotation from reset, or select behaviour when arbitration is compiled out
    for (int k = 0; k < 6; k++) begin
      exp_c = RR_ON ? (k % 4) : 1;
      drive(1'b1, 2'd1, 4'b1111, 1'b1, 32'(500 + k*10));
      #1;
      check($sformatf("rr%0d_in_ready", k), 64'(in_ready), 64'(4'b0001 << exp_c));
      tick;
      check($sformatf("rr%0d_out_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("rr%0d_out_chan", k),  64'(out_chan),  64'(exp_c));
      check($sformatf("rr%0d_out_data", k),  64'(out_data),  64'(500 + k*10 + exp_c));
    end

    // Randomized traffic against the reference model
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    m_vld = 1'b0; m_data = '0; m_chan = 0; m_ptr = 3;
    for (int t = 0; t < 400; t++) begin
      mode      = 1'($urandom_range(0, 1));
      control   = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 4; i++) begin
        rd[i] = $urandom;
        in_data[i*32 +: 32] = rd[i];
      end
      #1;
      g = ref_grant(mode, int'(control), in_valid, m_ptr);
      exp_ir = (g >= 0 && (!m_vld || out_ready)) ? (4'b0001 << g) : 4'b0000;
      check("rand_in_ready", 64'(in_ready), 64'(exp_ir));
      tick;
      if (g >= 0 && (!m_vld || out_ready)) begin
        m_vld  = 1'b1;
        m_data = rd[g];
        m_chan = g;
        m_ptr  = g;
      end else if (out_ready) begin
        m_vld = 1'b0;
      end
      check("rand_out_valid", 64'(out_valid), 64'(m_vld));
      check("rand_out_data",  64'(out_data),  64'(m_data));
      check("rand_out_chan",  64'(out_chan),  64'(m_chan));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
